// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: three 1-entry result buffers (ALU, LSB, BRU) granted
// round-robin onto a single registered broadcast port.
module cdb_arbiter #(
    parameter int RBW = 4,
    parameter int DW  = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rdy,
    input  logic           flush,
    input  logic           alu_valid,
    input  logic [RBW-1:0] alu_tag,
    input  logic [DW-1:0]  alu_val,
    input  logic           lsb_valid,
    input  logic [RBW-1:0] lsb_tag,
    input  logic [DW-1:0]  lsb_val,
    input  logic           bru_valid,
    input  logic [RBW-1:0] bru_tag,
    input  logic [DW-1:0]  bru_val,
    output logic           alu_ready,
    output logic           lsb_ready,
    output logic           bru_ready,
    output logic           cdb_valid,
    output logic [RBW-1:0] cdb_tag,
    output logic [DW-1:0]  cdb_val,
    output logic [1:0]     cdb_src
);

    localparam logic [1:0] SRC_BRU = 2'd2;

    logic [2:0]     in_v;
    logic [RBW-1:0] in_t [3];
    logic [DW-1:0]  in_d [3];

    logic [2:0]     buf_v;
    logic [RBW-1:0] buf_t [3];
    logic [DW-1:0]  buf_d [3];
    logic [1:0]     ptr;

    logic           gnt_any;
    logic [1:0]     gnt_idx;
    logic [2:0]     cand;
    logic [2:0]     ready;

    assign in_v    = {bru_valid, lsb_valid, alu_valid};
    assign in_t[0] = alu_tag;
    assign in_t[1] = lsb_tag;
    assign in_t[2] = bru_tag;
    assign in_d[0] = alu_val;
    assign in_d[1] = lsb_val;
    assign in_d[2] = bru_val;

    // Search the three buffers starting at ptr, wrapping modulo 3.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            cand = {1'b0, ptr} + 3'(k);
            if (cand >= 3'd3) cand = cand - 3'd3;
            if (!gnt_any && buf_v[cand[1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[1:0];
            end
        end
    end

    always_comb begin
        ready = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            ready[i] = rdy && !flush && !rst &&
                       (!buf_v[i] || (gnt_any && gnt_idx == 2'(i)));
        end
    end

    assign alu_ready = ready[0];
    assign lsb_ready = ready[1];
    assign bru_ready = ready[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_v     <= '0;
            ptr       <= '0;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_val   <= '0;
            cdb_src   <= '0;
        end else if (flush) begin
            buf_v     <= '0;
            ptr       <= '0;
            cdb_valid <= 1'b0;
        end else if (rdy) begin
            // A refill takes precedence over the free of a buffer granted at the same edge.
            for (int unsigned i = 0; i < 3; i++) begin
                if (in_v[i] && ready[i]) begin
                    buf_v[i] <= 1'b1;
                    buf_t[i] <= in_t[i];
                    buf_d[i] <= in_d[i];
                end else if (gnt_any && gnt_idx == 2'(i)) begin
                    buf_v[i] <= 1'b0;
                end
            end
            if (gnt_any) begin
                cdb_valid <= 1'b1;
                cdb_tag   <= buf_t[gnt_idx];
                cdb_val   <= buf_d[gnt_idx];
                cdb_src   <= gnt_idx;
                ptr       <= (gnt_idx == SRC_BRU) ? 2'd0 : gnt_idx + 2'd1;
            end else begin
                cdb_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter RBW, default 4: ROB tag width; the ROB holds 2^RBW entries.
REQ-002 Parameter DW, default 32: result data width.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port rdy, input, 1: global enable; low freezes all state.
REQ-006 Port flush, input, 1: mispredict squash; discards all pending results.
REQ-007 Ports alu_valid / lsb_valid / bru_valid, input, 1 each: requester 0/1/2 presents a result.
REQ-008 Ports alu_tag / lsb_tag / bru_tag, input, RBW each: ROB index of the result.
REQ-009 Ports alu_val / lsb_val / bru_val, input, DW each: result value.
REQ-010 Ports alu_ready / lsb_ready / bru_ready, output, 1 each: the requester's result is accepted this cycle.
REQ-011 Port cdb_valid, output, 1: broadcast valid; drives the ROB alu_flag.
REQ-012 Port cdb_tag, output, RBW: broadcast ROB index; drives rob_reorder.
REQ-013 Port cdb_val, output, DW: broadcast value; drives alu_val.
REQ-014 Port cdb_src, output, 2: granted requester (0=ALU, 1=LSB, 2=BRU; 3 never driven).

Function
REQ-015 Each requester SHALL own a 1-entry holding buffer (valid bit, tag, value).
REQ-016 x_ready SHALL be combinational:
- 1 when rdy=1, flush=0, rst=0, and the buffer is either empty or granted this cycle.
- 0 otherwise.
REQ-017 Acceptance: x_valid=1 and x_ready=1 at a rising edge loads the buffer; x_valid with x_ready=0 SHALL be ignored, and the requester holds it.
REQ-018 Each cycle with rdy=1 and flush=0, the arbiter SHALL grant exactly one occupied buffer, if any exists, in round-robin order starting at pointer ptr (2 bits, range 0..2).
REQ-019 On a grant to requester i:
- ptr becomes (i+1) mod 3.
- The buffer frees at the same edge.
- cdb_valid=1, cdb_tag, cdb_val and cdb_src=i are registered at that edge.
REQ-020 With no occupied buffer, cdb_valid SHALL register 0, ptr is unchanged, and cdb_tag/cdb_val/cdb_src hold their values.
REQ-021 Latency: a result accepted at edge k SHALL appear on the CDB no earlier than after edge k+1, and no later than after edge k+3.
REQ-022 Throughput: one broadcast per cycle; a continuously valid requester SHALL be accepted every cycle that it is granted (grant plus refill at the same edge).
REQ-023 Flush with rdy=1 or rdy=0: at the next edge all buffers SHALL clear, cdb_valid SHALL become 0, and ptr SHALL reset to 0; requests presented in the flush cycle are dropped.
REQ-024 With rdy=0 and flush=0, all registers SHALL hold, including cdb_valid; consumers gate on rdy.
REQ-025 Priority: rst, then flush, then rdy.
REQ-026 Tags and values SHALL pass through unmodified; there is no tag-conflict checking.

Reset
REQ-027 With rst=1 at an edge, regardless of rdy and flush:
- All buffers empty, ptr=0.
- cdb_valid=0, cdb_tag=0, cdb_val=0, cdb_src=0.
REQ-028 While rst=1, all x_ready outputs SHALL be 0.
REQ-029 A request in flight when reset is asserted mid-operation SHALL be discarded, and no broadcast of it SHALL occur after rst deasserts.

Verification
REQ-030 Single request: ALU presents tag=3, val=0x0000_00AA at edge 1 -> alu_ready=1; after edge 2, cdb_valid=1, cdb_tag=3, cdb_val=0xAA, cdb_src=0; after edge 3, cdb_valid=0.
REQ-031 Simultaneous requests: all three accepted at edge 1 with tags 1/2/5 -> broadcasts on consecutive cycles in order ALU(1), LSB(2), BRU(5); then ptr=0.
REQ-032 Fairness: ALU and LSB valid every cycle for 20 cycles -> grants alternate ALU, LSB, ALU, ...; no requester waits more than 2 grants.
REQ-033 Flush: two buffers occupied, flush=1 at edge n -> after edge n, cdb_valid=0 and buffers empty; no broadcast of either tag ever occurs.
REQ-034 Stall: cdb_valid=1 with tag=7 and rdy=0 for 4 cycles -> outputs frozen (tag=7), all x_ready=0; resumes correctly when rdy=1.
REQ-035 Reset mid-operation: rst=1 for one edge while LSB is buffered with tag=4 -> all reset values per REQ-027; tag 4 is never broadcast.
